// File: rtl/stk_rsp_q.sv
// Splits the shared stk response bus into per-engine FIFOs drained by valid/ready consumers.
// Overflow and multi-hot responses raise sticky error flags. Almost-full throttles issue upstream.
module stk_rsp_q #(
   parameter int ENGS_N = 4,
   parameter int DEPTH  = 4,
   parameter int W      = 128
) (
   input  logic                       clk,
   input  logic                       arst,
   input  logic [ENGS_N-1:0]          i_rsp_vld,
   input  logic [W-1:0]               i_rsp_dat,
   output logic [ENGS_N-1:0]          o_eng_vld,
   output logic [ENGS_N-1:0][W-1:0]   o_eng_dat,
   input  logic [ENGS_N-1:0]          i_eng_rdy,
   output logic [ENGS_N-1:0]          o_eng_afull,
   output logic [ENGS_N-1:0]          o_ovf,
   output logic                       o_err_mh
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL  = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_AFULL = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);

   logic multi_hot;

   // Clearing the lowest set bit leaves something only when two or more bits are set.
   assign multi_hot = (i_rsp_vld & (i_rsp_vld - ENGS_N'(1))) != '0;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge arst) begin
      if (arst)
         o_err_mh <= 1'b0;
      else if (multi_hot)
         o_err_mh <= 1'b1;
   end

   for (genvar e = 0; e < ENGS_N; e++) begin : g_eng
      logic [W-1:0]  mem [DEPTH];
      logic [W-1:0]  head;
      logic [AW-1:0] wr_ptr;
      logic [AW-1:0] rd_ptr;
      logic [AW-1:0] rd_nxt;
      logic [AW:0]   count;
      logic          ovf;
      logic          push_req;
      logic          push;
      logic          pop;
      logic          full;

      assign rd_nxt   = rd_ptr + 1'b1;
      assign full     = (count == CNT_FULL);
      assign pop      = (count != '0) && i_eng_rdy[e];
      assign push_req = i_rsp_vld[e] && !multi_hot;
      // A same-cycle pop frees the slot, so a full FIFO can still accept.
      assign push     = push_req && (!full || pop);

      always_ff @(posedge clk or posedge arst) begin
         if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + 1'b1;
            if (pop)
               rd_ptr <= rd_nxt;
            if (push && !pop)
               count <= count + 1'b1;
            else if (pop && !push)
               count <= count - 1'b1;
            if (push_req && !push)
               ovf <= 1'b1;
         end
      end

      // NOTE: storage and the head register carry no reset; they are only observed when count != 0.
      always_ff @(posedge clk) begin
         if (push)
            mem[wr_ptr] <= i_rsp_dat;
      end

      // Head is registered out of the array; an empty or emptying FIFO takes the incoming word directly.
      always_ff @(posedge clk) begin
         if (pop) begin
            if (count > CNT_ONE)
               head <= mem[rd_nxt];
            else if (push)
               head <= i_rsp_dat;
         end else if (push && count == '0) begin
            head <= i_rsp_dat;
         end
      end

      assign o_eng_vld[e]   = (count != '0);
      assign o_eng_afull[e] = (count >= CNT_AFULL);
      assign o_eng_dat[e]   = head;
      assign o_ovf[e]       = ovf;

      a_head_stable : assert property (@(posedge clk) disable iff (arst)
         (o_eng_vld[e] && !i_eng_rdy[e]) |=> $stable(o_eng_dat[e]));
      a_count_range : assert property (@(posedge clk) disable iff (arst)
         count <= CNT_FULL);
   end

endmodule

// File: tb/tb_stk_rsp_q.sv
// Directed bench for stk_rsp_q: the stimulus process queues expected heads per engine,
// a negedge monitor compares every accepted head against those queues.
module tb_stk_rsp_q;

   localparam int ENGS_N = 4;
   localparam int DEPTH  = 4;
   localparam int W      = 128;

   logic                     clk = 1'b0;
   logic                     arst;
   logic [ENGS_N-1:0]        rsp_vld;
   logic [W-1:0]             rsp_dat;
   logic [ENGS_N-1:0]        eng_vld;
   logic [ENGS_N-1:0][W-1:0] eng_dat;
   logic [ENGS_N-1:0]        eng_rdy;
   logic [ENGS_N-1:0]        eng_afull;
   logic [ENGS_N-1:0]        ovf;
   logic                     err_mh;

   logic [W-1:0] exp_q [ENGS_N][$];
   int n_cmp = 0;
   int n_err = 0;

   stk_rsp_q #(.ENGS_N(ENGS_N), .DEPTH(DEPTH), .W(W)) dut (
      .clk         (clk),
      .arst        (arst),
      .i_rsp_vld   (rsp_vld),
      .i_rsp_dat   (rsp_dat),
      .o_eng_vld   (eng_vld),
      .o_eng_dat   (eng_dat),
      .i_eng_rdy   (eng_rdy),
      .o_eng_afull (eng_afull),
      .o_ovf       (ovf),
      .o_err_mh    (err_mh)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every head accepted by a consumer must match the oldest expected entry.
   always @(negedge clk) begin
      if (!arst) begin
         for (int e = 0; e < ENGS_N; e++) begin
            if (eng_vld[e] && eng_rdy[e]) begin
               if (exp_q[e].size() == 0)
                  check($sformatf("unexpected_pop_eng%0d", e), eng_dat[e], '1);
               else
                  check($sformatf("head_eng%0d", e), eng_dat[e], exp_q[e].pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int e, input logic [W-1:0] d, input bit accept);
      rsp_vld = ENGS_N'(1) << e;
      rsp_dat = d;
      if (accept)
         exp_q[e].push_back(d);
      tick();
      rsp_vld = '0;
      rsp_dat = '0;
   endtask

   task automatic flags(input string name, input logic [3:0] vld, input logic [3:0] af,
                        input logic [3:0] ov, input logic mh);
      @(negedge clk);
      check({name, "_vld"},   W'(eng_vld),   W'(vld));
      check({name, "_afull"}, W'(eng_afull), W'(af));
      check({name, "_ovf"},   W'(ovf),       W'(ov));
      check({name, "_mh"},    W'(err_mh),    W'(mh));
   endtask

   initial begin
      arst    = 1'b1;
      rsp_vld = '0;
      rsp_dat = '0;
      eng_rdy = '0;
      #12;
      check("reset_vld",   W'(eng_vld),   '0);
      check("reset_afull", W'(eng_afull), '0);
      check("reset_ovf",   W'(ovf),       '0);
      check("reset_mh",    W'(err_mh),    '0);
      arst = 1'b0;
      tick();

      // 1: single push to eng 2, consumer ready; one-cycle latency, gone the cycle after.
      eng_rdy = 4'b1111;
      push(2, 128'hA5, 1'b1);
      flags("t1_t1", 4'b0100, 4'b0000, 4'b0000, 1'b0);
      tick();
      flags("t1_t2", 4'b0000, 4'b0000, 4'b0000, 1'b0);

      // 2: fill eng 0 while stalled, afull after the 3rd push, then drain in order.
      eng_rdy = 4'b0000;
      push(0, 128'h1, 1'b1);
      push(0, 128'h2, 1'b1);
      flags("t2_two", 4'b0001, 4'b0000, 4'b0000, 1'b0);
      push(0, 128'h3, 1'b1);
      flags("t2_three", 4'b0001, 4'b0001, 4'b0000, 1'b0);
      push(0, 128'h4, 1'b1);
      flags("t2_full", 4'b0001, 4'b0001, 4'b0000, 1'b0);
      eng_rdy = 4'b0001;
      repeat (4) tick();
      flags("t2_drained", 4'b0000, 4'b0000, 4'b0000, 1'b0);

      // 4: eng 1 full, push coincides with pop; accepted, no overflow.
      eng_rdy = 4'b0000;
      push(1, 128'h21, 1'b1);
      push(1, 128'h22, 1'b1);
      push(1, 128'h23, 1'b1);
      push(1, 128'h24, 1'b1);
      eng_rdy = 4'b0010;
      push(1, 128'h9, 1'b1);
      flags("t4_after", 4'b0010, 4'b0010, 4'b0000, 1'b0);
      repeat (4) tick();
      flags("t4_drained", 4'b0000, 4'b0000, 4'b0000, 1'b0);

      // 3: eng 1 full and stalled; 5th push dropped, overflow sticky.
      eng_rdy = 4'b0000;
      push(1, 128'h11, 1'b1);
      push(1, 128'h12, 1'b1);
      push(1, 128'h13, 1'b1);
      push(1, 128'h14, 1'b1);
      push(1, 128'h5, 1'b0);
      flags("t3_ovf", 4'b0010, 4'b0010, 4'b0010, 1'b0);
      eng_rdy = 4'b0010;
      repeat (5) tick();
      flags("t3_drained", 4'b0000, 4'b0000, 4'b0010, 1'b0);

      // 5: multi-hot response writes nothing; later one-hot pushes still land.
      eng_rdy = 4'b0000;
      rsp_vld = 4'b0101;
      rsp_dat = 128'hBAD;
      tick();
      rsp_vld = '0;
      flags("t5_mh", 4'b0000, 4'b0000, 4'b0010, 1'b1);
      push(0, 128'h55, 1'b1);
      push(2, 128'h66, 1'b1);
      flags("t5_after", 4'b0101, 4'b0000, 4'b0010, 1'b1);
      eng_rdy = 4'b0101;
      tick();
      flags("t5_drained", 4'b0000, 4'b0000, 4'b0010, 1'b1);

      // 6: reset mid-operation with eng 3 holding three entries.
      eng_rdy = 4'b0000;
      push(3, 128'h31, 1'b1);
      push(3, 128'h32, 1'b1);
      push(3, 128'h33, 1'b1);
      #2 arst = 1'b1;
      #1;
      check("t6_rst_vld",   W'(eng_vld),   '0);
      check("t6_rst_afull", W'(eng_afull), '0);
      check("t6_rst_ovf",   W'(ovf),       '0);
      check("t6_rst_mh",    W'(err_mh),    '0);
      exp_q[3].delete();
      #2 arst = 1'b0;
      tick();
      push(3, 128'h7, 1'b1);
      flags("t6_push", 4'b1000, 4'b0000, 4'b0000, 1'b0);
      eng_rdy = 4'b1000;
      tick();
      flags("t6_drained", 4'b0000, 4'b0000, 4'b0000, 1'b0);

      for (int e = 0; e < ENGS_N; e++)
         check($sformatf("leftover_eng%0d", e), W'(exp_q[e].size()), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
